// File: rtl/wb_ram_arbiter.sv
// Round-robin arbiter sharing one single-port DFFRAM256x32 macro between two
// pipelined Wishbone masters, with fixed two-cycle ack latency.
module wb_ram_arbiter #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 32,
    parameter int unsigned SW = DW / 8,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          p0_stb,
    input  logic          p0_we,
    input  logic [SW-1:0] p0_sel,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_dat_i,
    output logic          p0_ack,
    output logic [DW-1:0] p0_dat_o,
    output logic          p0_stall,

    input  logic          p1_stb,
    input  logic          p1_we,
    input  logic [SW-1:0] p1_sel,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_dat_i,
    output logic          p1_ack,
    output logic [DW-1:0] p1_dat_o,
    output logic          p1_stall,

    output logic          ram_en,
    output logic [SW-1:0] ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_di,
    input  logic [DW-1:0] ram_do,

    input  logic          clr_cnt,
    output logic [CW-1:0] conflict_cnt
);

    logic gnt0, gnt1;
    logic last_gnt_q;  // index of the port granted most recently
    logic v1_q, port1_q, we1_q;

    // On a conflict the port that did not win last time is granted.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (p0_stb && p1_stb) begin
                gnt0 = last_gnt_q;
                gnt1 = ~last_gnt_q;
            end else begin
                gnt0 = p0_stb;
                gnt1 = p1_stb;
            end
        end
    end

    assign p0_stall = p0_stb & ~gnt0;
    assign p1_stall = p1_stb & ~gnt1;

    always_comb begin
        ram_en   = gnt0 | gnt1;
        ram_we   = '0;
        ram_addr = p0_addr;
        ram_di   = p0_dat_i;
        if (gnt1) begin
            ram_addr = p1_addr;
            ram_di   = p1_dat_i;
            ram_we   = p1_we ? p1_sel : '0;
        end else if (gnt0) begin
            ram_we   = p0_we ? p0_sel : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_gnt_q <= 1'b1;
        end else if (gnt0 || gnt1) begin
            last_gnt_q <= gnt1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q    <= 1'b0;
            port1_q <= 1'b0;
            we1_q   <= 1'b0;
        end else begin
            v1_q    <= gnt0 | gnt1;
            port1_q <= gnt1;
            we1_q   <= gnt1 ? p1_we : p0_we;
        end
    end

    // Macro Do is valid the cycle after the access, so capture it here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p0_ack   <= 1'b0;
            p1_ack   <= 1'b0;
            p0_dat_o <= '0;
            p1_dat_o <= '0;
        end else begin
            p0_ack <= v1_q & ~port1_q;
            p1_ack <= v1_q & port1_q;
            if (v1_q && !we1_q && !port1_q) begin
                p0_dat_o <= ram_do;
            end
            if (v1_q && !we1_q && port1_q) begin
                p1_dat_o <= ram_do;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_cnt <= '0;
        end else if (clr_cnt) begin
            conflict_cnt <= '0;
        end else if (p0_stb && p1_stb && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Directed bench for wb_ram_arbiter: per-cycle vector table plus hand-written
// sequences for fairness, reset-in-flight and counter saturation.
module tb_wb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_stb, p0_we, p1_stb, p1_we;
    logic [3:0]  p0_sel, p1_sel;
    logic [7:0]  p0_addr, p1_addr;
    logic [31:0] p0_dat_i, p1_dat_i;
    logic        p0_ack, p1_ack, p0_stall, p1_stall;
    logic [31:0] p0_dat_o, p1_dat_o;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [7:0]  ram_addr;
    logic [31:0] ram_di, ram_do;
    logic        clr_cnt;
    logic [15:0] conflict_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_ram_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .p0_stb       (p0_stb),
        .p0_we        (p0_we),
        .p0_sel       (p0_sel),
        .p0_addr      (p0_addr),
        .p0_dat_i     (p0_dat_i),
        .p0_ack       (p0_ack),
        .p0_dat_o     (p0_dat_o),
        .p0_stall     (p0_stall),
        .p1_stb       (p1_stb),
        .p1_we        (p1_we),
        .p1_sel       (p1_sel),
        .p1_addr      (p1_addr),
        .p1_dat_i     (p1_dat_i),
        .p1_ack       (p1_ack),
        .p1_dat_o     (p1_dat_o),
        .p1_stall     (p1_stall),
        .ram_en       (ram_en),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_di       (ram_di),
        .ram_do       (ram_do),
        .clr_cnt      (clr_cnt),
        .conflict_cnt (conflict_cnt)
    );

    // Behavioural DFFRAM256x32: byte-write, registered read.
    logic [31:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        ram_do = 32'h0;
    end
    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_di[8*b +: 8];
            end
            ram_do <= mem[ram_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] m0, input logic [3:0] s0, input logic [7:0] a0,
                         input logic [31:0] d0, input logic [1:0] m1, input logic [3:0] s1,
                         input logic [7:0] a1, input logic [31:0] d1);
        {p0_stb, p0_we} = m0;
        p0_sel = s0; p0_addr = a0; p0_dat_i = d0;
        {p1_stb, p1_we} = m1;
        p1_sel = s1; p1_addr = a1; p1_dat_i = d1;
    endtask

    // m = {stb, we}; flags = {stall0, stall1, ack0, ack1, ram_en}
    typedef struct {
        logic [1:0]  m0;
        logic [3:0]  s0;
        logic [7:0]  a0;
        logic [31:0] d0;
        logic [1:0]  m1;
        logic [3:0]  s1;
        logic [7:0]  a1;
        logic [31:0] d1;
        logic [4:0]  flags;
        logic [31:0] do0;
        logic [31:0] do1;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl [20];

    initial begin
        tbl[0]  = '{2'b11, 4'hF, 8'h10, 32'hDEADBEEF, 2'b00, 4'h0, 8'h00, 32'h0,
                    5'b00001, 32'h0, 32'h0, 16'd0};
        tbl[1]  = '{2'b10, 4'hF, 8'h10, 32'h0, 2'b00, 4'h0, 8'h00, 32'h0,
                    5'b00001, 32'h0, 32'h0, 16'd0};
        tbl[2]  = '{2'b00, 4'h0, 8'h00, 32'h0, 2'b00, 4'h0, 8'h00, 32'h0,
                    5'b00100, 32'h0, 32'h0, 16'd0};
        tbl[3]  = '{2'b00, 4'h0, 8'h00, 32'h0, 2'b00, 4'h0, 8'h00, 32'h0,
                    5'b00100, 32'hDEADBEEF, 32'h0, 16'd0};
        tbl[4]  = '{2'b11, 4'hF, 8'h30, 32'h11223344, 2'b00, 4'h0, 8'h00, 32'h0,
                    5'b00001, 32'hDEADBEEF, 32'h0, 16'd0};
        tbl[5]  = '{2'b11, 4'h1, 8'h30, 32'h000000AA, 2'b00, 4'h0, 8'h00, 32'h0,
                    5'b00001, 32'hDEADBEEF, 32'h0, 16'd0};
        tbl[6]  = '{2'b10, 4'hF, 8'h30, 32'h0, 2'b00, 4'h0, 8'h00, 32'h0,
                    5'b00101, 32'hDEADBEEF, 32'h0, 16'd0};
        tbl[7]  = '{2'b11, 4'hF, 8'h20, 32'h5, 2'b00, 4'h0, 8'h00, 32'h0,
                    5'b00101, 32'hDEADBEEF, 32'h0, 16'd0};
        tbl[8]  = '{2'b00, 4'h0, 8'h00, 32'h0, 2'b10, 4'hF, 8'h20, 32'h0,
                    5'b00101, 32'h112233AA, 32'h0, 16'd0};
        tbl[9]  = '{2'b00, 4'h0, 8'h00, 32'h0, 2'b00, 4'h0, 8'h00, 32'h0,
                    5'b00100, 32'h112233AA, 32'h0, 16'd0};
        tbl[10] = '{2'b00, 4'h0, 8'h00, 32'h0, 2'b00, 4'h0, 8'h00, 32'h0,
                    5'b00010, 32'h112233AA, 32'h5, 16'd0};
        tbl[11] = '{2'b10, 4'hF, 8'h10, 32'h0, 2'b10, 4'hF, 8'h30, 32'h0,
                    5'b01001, 32'h112233AA, 32'h5, 16'd0};
        tbl[12] = '{2'b10, 4'hF, 8'h10, 32'h0, 2'b10, 4'hF, 8'h30, 32'h0,
                    5'b10001, 32'h112233AA, 32'h5, 16'd1};
        tbl[13] = '{2'b10, 4'hF, 8'h10, 32'h0, 2'b10, 4'hF, 8'h30, 32'h0,
                    5'b01101, 32'hDEADBEEF, 32'h5, 16'd2};
        tbl[14] = '{2'b00, 4'h0, 8'h00, 32'h0, 2'b00, 4'h0, 8'h00, 32'h0,
                    5'b00010, 32'hDEADBEEF, 32'h112233AA, 16'd3};
        tbl[15] = '{2'b00, 4'h0, 8'h00, 32'h0, 2'b00, 4'h0, 8'h00, 32'h0,
                    5'b00100, 32'hDEADBEEF, 32'h112233AA, 16'd3};
        tbl[16] = '{2'b00, 4'h0, 8'h00, 32'h0, 2'b11, 4'h0, 8'h10, 32'hFFFFFFFF,
                    5'b00001, 32'hDEADBEEF, 32'h112233AA, 16'd3};
        tbl[17] = '{2'b00, 4'h0, 8'h00, 32'h0, 2'b10, 4'hF, 8'h10, 32'h0,
                    5'b00001, 32'hDEADBEEF, 32'h112233AA, 16'd3};
        tbl[18] = '{2'b00, 4'h0, 8'h00, 32'h0, 2'b00, 4'h0, 8'h00, 32'h0,
                    5'b00010, 32'hDEADBEEF, 32'h112233AA, 16'd3};
        tbl[19] = '{2'b00, 4'h0, 8'h00, 32'h0, 2'b00, 4'h0, 8'h00, 32'h0,
                    5'b00010, 32'hDEADBEEF, 32'hDEADBEEF, 16'd3};

        reset   = 1'b1;
        clr_cnt = 1'b0;
        drive(2'b00, 4'h0, 8'h00, 32'h0, 2'b00, 4'h0, 8'h00, 32'h0);
        repeat (3) @(negedge clk);
        check("reset_ack0", {31'h0, p0_ack}, 32'h0);
        check("reset_ack1", {31'h0, p1_ack}, 32'h0);
        check("reset_dat0", p0_dat_o, 32'h0);
        check("reset_cnt", {16'h0, conflict_cnt}, 32'h0);
        reset = 1'b0;

        // Cycle-by-cycle vector table.
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            drive(tbl[i].m0, tbl[i].s0, tbl[i].a0, tbl[i].d0,
                  tbl[i].m1, tbl[i].s1, tbl[i].a1, tbl[i].d1);
            @(negedge clk);
            check($sformatf("v%0d_flags", i),
                  {27'h0, p0_stall, p1_stall, p0_ack, p1_ack, ram_en}, {27'h0, tbl[i].flags});
            check($sformatf("v%0d_dat0", i), p0_dat_o, tbl[i].do0);
            check($sformatf("v%0d_dat1", i), p1_dat_o, tbl[i].do1);
            check($sformatf("v%0d_cnt", i), {16'h0, conflict_cnt}, {16'h0, tbl[i].cnt});
        end
        check("byte_write_mem", mem[8'h30], 32'h112233AA);
        check("sel0_write_mem", mem[8'h10], 32'hDEADBEEF);

        // Six cycles of continuous contention straight after reset.
        @(posedge clk);
        #1;
        drive(2'b00, 4'h0, 8'h00, 32'h0, 2'b00, 4'h0, 8'h00, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (k < 6) drive(2'b10, 4'hF, 8'h10, 32'h0, 2'b10, 4'hF, 8'h30, 32'h0);
            else drive(2'b00, 4'h0, 8'h00, 32'h0, 2'b00, 4'h0, 8'h00, 32'h0);
            @(negedge clk);
            check($sformatf("rr%0d_stall0", k), {31'h0, p0_stall}, (k < 6 && k % 2 == 1) ? 1 : 0);
            check($sformatf("rr%0d_stall1", k), {31'h0, p1_stall}, (k < 6 && k % 2 == 0) ? 1 : 0);
            check($sformatf("rr%0d_ack0", k), {31'h0, p0_ack}, (k >= 2 && k % 2 == 0) ? 1 : 0);
            check($sformatf("rr%0d_ack1", k), {31'h0, p1_ack}, (k >= 3 && k % 2 == 1) ? 1 : 0);
        end
        check("rr_cnt", {16'h0, conflict_cnt}, 32'd6);
        check("rr_dat0", p0_dat_o, 32'hDEADBEEF);
        check("rr_dat1", p1_dat_o, 32'h112233AA);

        // Reset one cycle after an accepted read drops the access.
        @(posedge clk);
        #1;
        drive(2'b10, 4'hF, 8'h30, 32'h0, 2'b00, 4'h0, 8'h00, 32'h0);
        @(posedge clk);
        #1;
        drive(2'b10, 4'hF, 8'h30, 32'h0, 2'b00, 4'h0, 8'h00, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_ram_en", {31'h0, ram_en}, 32'h0);
        check("rst_stall0", {31'h0, p0_stall}, 32'h1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("rst%0d_ack0", k), {31'h0, p0_ack}, 32'h0);
            check($sformatf("rst%0d_dat0", k), p0_dat_o, 32'h0);
        end
        drive(2'b00, 4'h0, 8'h00, 32'h0, 2'b00, 4'h0, 8'h00, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        drive(2'b10, 4'hF, 8'h10, 32'h0, 2'b10, 4'hF, 8'h30, 32'h0);
        @(negedge clk);
        check("post_rst_stall0", {31'h0, p0_stall}, 32'h0);
        check("post_rst_stall1", {31'h0, p1_stall}, 32'h1);
        check("post_rst_ack0", {31'h0, p0_ack}, 32'h0);

        // Counter saturation under sustained contention, then clear.
        repeat (65541) @(posedge clk);
        @(negedge clk);
        check("cnt_saturate", {16'h0, conflict_cnt}, 32'h0000FFFF);
        clr_cnt = 1'b1;
        @(negedge clk);
        check("cnt_clear", {16'h0, conflict_cnt}, 32'h0);
        clr_cnt = 1'b0;
        @(negedge clk);
        check("cnt_after_clear", {16'h0, conflict_cnt}, 32'h1);
        drive(2'b00, 4'h0, 8'h00, 32'h0, 2'b00, 4'h0, 8'h00, 32'h0);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    always @(negedge clk) begin
        if (p0_ack && p1_ack) begin
            failures++;
            $display("FAIL dual_ack: got p0_ack=1 p1_ack=1, expected at most one");
        end
    end

endmodule

// File: doc/wb_ram_arbiter.md
Name: wb_ram_arbiter

Overview:
Two-port Wishbone (pipelined, B4-style stb/stall/ack) arbiter that shares one single-port DFFRAM256x32 macro between two masters.
- Round-robin arbitration: at most one RAM access per cycle; a stalled requester waits no more than one cycle.
- Drives the macro's EN/WE/A/Di pins and returns read data with a fixed two-cycle ack latency.
- Provides a saturating contention counter for performance debug.
- Sits between the two bus masters and a single externally instantiated RAM macro.

Parameters:
AW, 8, address width (256 words)
DW, 32, data width
SW, DW/8, byte-select width
CW, 16, contention counter width

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
p0_stb  input  1  port 0 request strobe
p0_we  input  1  port 0 write enable
p0_sel  input  SW  port 0 byte selects
p0_addr  input  AW  port 0 word address
p0_dat_i  input  DW  port 0 write data
p0_ack  output  1  port 0 transfer complete, one-cycle pulse
p0_dat_o  output  DW  port 0 read data
p0_stall  output  1  port 0 request not accepted this cycle
p1_stb, p1_we, p1_sel, p1_addr, p1_dat_i, p1_ack, p1_dat_o, p1_stall  same as port 0, for port 1
ram_en  output  1  macro EN0
ram_we  output  SW  macro WE0 byte enables
ram_addr  output  AW  macro A0
ram_di  output  DW  macro Di0
ram_do  input  DW  macro Do0; valid the cycle after an enabled access
clr_cnt  input  1  synchronous clear of conflict_cnt
conflict_cnt  output  CW  count of cycles where both strobes are high

Behaviour:
- Reset values (async): p0_ack=p1_ack=0, p0_dat_o=p1_dat_o=0, conflict_cnt=0, last_gnt=1 (port 0 wins the first conflict), pipeline valid bits=0.
- While reset is high, gnt0=gnt1=0 and ram_en=0.
- Grant is combinational in cycle N:
  - only p0_stb high: gnt0
  - only p1_stb high: gnt1
  - both high: grant the port != last_gnt
  - neither high: no grant
- last_gnt updates on every cycle with a grant.
- pX_stall = pX_stb & ~gntX. Stall is never high while stb is low.
- A transfer is accepted when pX_stb & ~pX_stall.
- Accepted cycle N, RAM side:
  - ram_en=1, ram_addr=pX_addr, ram_di=pX_dat_i
  - ram_we = pX_we ? pX_sel : 0
- With no grant: ram_en=0, ram_we=0; addr/di don't-care (drive port 0 values).
- Stage 1 register, loaded at edge N: {v1, port, we}.
- Stage 2, at edge N+1 when v1:
  - pPort_ack <= 1
  - if a read, pPort_dat_o <= ram_do; a write leaves dat_o holding its last read value.
- Ack is therefore high during cycle N+2, for exactly one cycle.
- The pipeline is fully pipelined: back-to-back accepts, including alternating ports, give acks on consecutive cycles, in order.
- A port's ack never coincides with another of that port's acks; the two ports' acks may both be high only if… never. Only one access per cycle is issued, so at most one ack is high per cycle.
- Read-after-write: a port 0 write at N and a port 1 read of the same address at N+1 returns the new data.
- Writes with sel=0 are accepted and acked with no RAM modification.
- conflict_cnt:
  - increments each cycle p0_stb & p1_stb, saturating at 2^CW-1
  - clr_cnt has priority over increment
- Reset mid-operation: in-flight accesses are dropped and no ack is generated. Masters must reissue after reset.

Test Plan:
- Single port 0 write of 0xDEADBEEF to addr 0x10, sel=1111, then a read of 0x10 -> p0_ack in cycle N+2 for each; p0_dat_o=0xDEADBEEF; p0_stall=0 throughout.
- Both ports strobe continuously for 6 cycles after reset -> grants alternate p0,p1,p0,…; each port's stall alternates; conflict_cnt=6; acks alternate, at most one per cycle.
- Byte write 0x000000AA with sel=0001 to a word holding 0x11223344, then read -> 0x112233AA.
- Port 0 writes 0x5 to addr 0x20 at N, port 1 reads 0x20 at N+1 -> p1_ack at N+3 with p1_dat_o=0x5.
- Hold both strobes for 2^16+5 cycles -> conflict_cnt saturates at 0xFFFF; pulse clr_cnt with both strobes high -> 0 on the next cycle.
- Assert reset one cycle after an accepted read -> no ack, dat_o=0, last_gnt=1; the first post-reset conflict is granted to port 0.
